pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_decoder.sv | 45 ++++
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants, ALU encodings, FSM state encoding and the decoded-control bundle
// used by pipe_ctrl and pipe_ctrl_decoder.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_BR    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RUN   = 3'd1;
  localparam state_t ST_STALL = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  // readsSrc marks opcodes whose src fields take part in load-use detection
  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       memToReg;
    logic       immediate;
    logic       branch;
    logic       halt;
    logic       readsSrc;
    logic [1:0] aluFunc;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_decoder.sv
// Pure combinational opcode-to-control mapping; the FSM in pipe_ctrl decides
// whether these controls are actually applied.
module pipe_ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR): begin
        ctrl.regWrite = 1'b1;
        ctrl.readsSrc = 1'b1;
        ctrl.aluFunc  = opcode[1:0];
      end
      OPW'(OP_ADDI): begin
        ctrl.regWrite  = 1'b1;
        ctrl.immediate = 1'b1;
        ctrl.readsSrc  = 1'b1;
        ctrl.aluFunc   = ALU_ADD;
      end
      OPW'(OP_LOAD): begin
        ctrl.regWrite  = 1'b1;
        ctrl.memToReg  = 1'b1;
        ctrl.immediate = 1'b1;
        ctrl.readsSrc  = 1'b1;
        ctrl.aluFunc   = ALU_ADD;
      end
      OPW'(OP_STORE): begin
        ctrl.memWrite  = 1'b1;
        ctrl.immediate = 1'b1;
        ctrl.readsSrc  = 1'b1;
        ctrl.aluFunc   = ALU_ADD;
      end
      OPW'(OP_BR):   ctrl.branch = 1'b1;
      OPW'(OP_HALT): ctrl.halt   = 1'b1;
      default:       ctrl = '0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control FSM with load-use hazard record and optional performance
// counters (enabled by defining PIPE_CTRL_PERF_EN).
//
// state | meaning
// IDLE  | waiting for start; pipeline held, execute fed bubbles
// RUN   | normal issue; checks halt, load-use and branch
// STALL | one-cycle re-issue of the instruction held by a load-use bubble
// FLUSH | squash the wrong-path instruction behind a taken branch
// HALT  | pipeline frozen until reset
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     inst_d,
  output logic            enable,
  output logic            branchC,
  output logic            flushC,
  output logic            RegWriteC,
  output logic            MemWriteC,
  output logic            MemToRegC,
  output logic            immediateC,
  output logic [1:0]      alufuncC,
  output logic            busy,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  state_t     state, nextState;
  logic       loadE;
  logic [3:0] loadDest;
  logic       issue;
  logic       hazard;
  ctrl_t      ctrl;

  pipe_ctrl_decoder #(.OPW(OPW)) uDecoder (
    .opcode (inst_d[15 -: OPW]),
    .ctrl   (ctrl)
  );

  assign hazard = loadE && ctrl.readsSrc &&
                  ((inst_d[7:4] == loadDest) || (inst_d[3:0] == loadDest));

  always_comb begin
    nextState  = state;
    enable     = 1'b0;
    branchC    = 1'b0;
    flushC     = 1'b0;
    RegWriteC  = 1'b0;
    MemWriteC  = 1'b0;
    MemToRegC  = 1'b0;
    immediateC = 1'b0;
    alufuncC   = ALU_ADD;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        flushC = 1'b1;
        if (start) nextState = ST_RUN;
      end
      ST_RUN: begin
        if (ctrl.halt) begin
          flushC    = 1'b1;
          nextState = ST_HALT;
        end else if (hazard) begin
          flushC    = 1'b1;
          nextState = ST_STALL;
        end else begin
          enable     = 1'b1;
          issue      = 1'b1;
          branchC    = ctrl.branch;
          RegWriteC  = ctrl.regWrite;
          MemWriteC  = ctrl.memWrite;
          MemToRegC  = ctrl.memToReg;
          immediateC = ctrl.immediate;
          alufuncC   = ctrl.aluFunc;
          if (ctrl.branch) nextState = ST_FLUSH;
        end
      end
      ST_STALL: begin
        enable     = 1'b1;
        issue      = 1'b1;
        RegWriteC  = ctrl.regWrite;
        MemWriteC  = ctrl.memWrite;
        MemToRegC  = ctrl.memToReg;
        immediateC = ctrl.immediate;
        alufuncC   = ctrl.aluFunc;
        nextState  = ST_RUN;
      end
      ST_FLUSH: begin
        enable    = 1'b1;
        flushC    = 1'b1;
        nextState = ST_RUN;
      end
      ST_HALT: flushC = 1'b1;
      default: begin
        flushC    = 1'b1;
        nextState = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state == ST_RUN) || (state == ST_STALL) || (state == ST_FLUSH);
  assign halted = (state == ST_HALT);

  // Bubbles and squashed instructions never set the load record
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      loadE    <= 1'b0;
      loadDest <= 4'h0;
    end else begin
      state    <= nextState;
      loadE    <= issue && ctrl.memToReg;
      loadDest <= inst_d[11:8];
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNTW-1:0] stallCnt, flushCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if ((state == ST_STALL) && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      if ((state == ST_FLUSH) && (flushCnt != '1)) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign stall_cnt = stallCnt;
  assign flush_cnt = flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: one table entry per clock cycle with
// hand-computed control outputs, status flags and counter values.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] inst_d;
  logic        enable, branchC, flushC, RegWriteC, MemWriteC, MemToRegC, immediateC;
  logic [1:0]  alufuncC;
  logic        busy, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int passCnt = 0;
  int totalCnt = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  pipe_ctrl #(.OPW(4), .CNTW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .inst_d     (inst_d),
    .enable     (enable),
    .branchC    (branchC),
    .flushC     (flushC),
    .RegWriteC  (RegWriteC),
    .MemWriteC  (MemWriteC),
    .MemToRegC  (MemToRegC),
    .immediateC (immediateC),
    .alufuncC   (alufuncC),
    .busy       (busy),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic [15:0] inst;
    logic [8:0]  ctl;   // {enable, branchC, flushC, RegWrite, MemWrite, MemToReg, immediate, alufunc}
    logic        bsy;
    logic        hlt;
    int          s;
    int          f;
  } vec_t;

  vec_t vecs[$];

  task automatic addV(input logic rst, input logic st, input logic [15:0] inst,
                      input logic [8:0] ctl, input logic bsy, input logic hlt,
                      input int s, input int f);
    vec_t v;
    v.rst = rst; v.st = st; v.inst = inst; v.ctl = ctl;
    v.bsy = bsy; v.hlt = hlt; v.s = s; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passCnt++;
  endtask

  localparam logic [8:0] C_IDLE  = 9'b0_0_1_0_0_0_0_00;
  localparam logic [8:0] C_NOP   = 9'b1_0_0_0_0_0_0_00;
  localparam logic [8:0] C_ADD   = 9'b1_0_0_1_0_0_0_00;
  localparam logic [8:0] C_SUB   = 9'b1_0_0_1_0_0_0_01;
  localparam logic [8:0] C_AND   = 9'b1_0_0_1_0_0_0_10;
  localparam logic [8:0] C_OR    = 9'b1_0_0_1_0_0_0_11;
  localparam logic [8:0] C_ADDI  = 9'b1_0_0_1_0_0_1_00;
  localparam logic [8:0] C_LOAD  = 9'b1_0_0_1_0_1_1_00;
  localparam logic [8:0] C_STORE = 9'b1_0_0_0_1_0_1_00;
  localparam logic [8:0] C_BR    = 9'b1_1_0_0_0_0_0_00;
  localparam logic [8:0] C_FLUSH = 9'b1_0_1_0_0_0_0_00;

  initial begin
    //   rst   st    inst      ctl      bsy   hlt   S  F
    addV(1'b1, 1'b0, 16'h0000, C_IDLE,  1'b0, 1'b0, 0, 0); // 0  IDLE under reset
    addV(1'b0, 1'b1, 16'h1123, C_IDLE,  1'b0, 1'b0, 0, 0); // 1  start pulse
    addV(1'b0, 1'b0, 16'h1123, C_SUB,   1'b1, 1'b0, 0, 0); // 2  SUB r1,r2,r3
    addV(1'b0, 1'b0, 16'h4123, C_ADDI,  1'b1, 1'b0, 0, 0); // 3
    addV(1'b0, 1'b0, 16'h2000, C_AND,   1'b1, 1'b0, 0, 0); // 4
    addV(1'b0, 1'b0, 16'h3000, C_OR,    1'b1, 1'b0, 0, 0); // 5
    addV(1'b0, 1'b0, 16'h6000, C_STORE, 1'b1, 1'b0, 0, 0); // 6
    addV(1'b0, 1'b0, 16'h7000, C_NOP,   1'b1, 1'b0, 0, 0); // 7
    addV(1'b0, 1'b0, 16'h5400, C_LOAD,  1'b1, 1'b0, 0, 0); // 8  LOAD r4
    addV(1'b0, 1'b0, 16'h0541, C_IDLE,  1'b1, 1'b0, 0, 0); // 9  load-use on src1
    addV(1'b0, 1'b0, 16'h0541, C_ADD,   1'b1, 1'b0, 0, 0); // 10 STALL issues ADD
    addV(1'b0, 1'b0, 16'h5400, C_LOAD,  1'b1, 1'b0, 1, 0); // 11
    addV(1'b0, 1'b0, 16'h7444, C_NOP,   1'b1, 1'b0, 1, 0); // 12 opcode 7 never stalls
    addV(1'b0, 1'b0, 16'h5900, C_LOAD,  1'b1, 1'b0, 1, 0); // 13 LOAD r9
    addV(1'b0, 1'b0, 16'h6019, C_IDLE,  1'b1, 1'b0, 1, 0); // 14 load-use on src2
    addV(1'b0, 1'b0, 16'h6019, C_STORE, 1'b1, 1'b0, 1, 0); // 15 STALL issues STORE
    addV(1'b0, 1'b0, 16'h5400, C_LOAD,  1'b1, 1'b0, 2, 0); // 16
    addV(1'b0, 1'b0, 16'h0123, C_ADD,   1'b1, 1'b0, 2, 0); // 17 no register match
    addV(1'b0, 1'b0, 16'h5400, C_LOAD,  1'b1, 1'b0, 2, 0); // 18
    addV(1'b0, 1'b0, 16'h0000, C_ADD,   1'b1, 1'b0, 2, 0); // 19 no match
    addV(1'b0, 1'b0, 16'h0541, C_ADD,   1'b1, 1'b0, 2, 0); // 20 load two cycles back
    addV(1'b0, 1'b0, 16'h8000, C_BR,    1'b1, 1'b0, 2, 0); // 21 BR
    addV(1'b0, 1'b0, 16'h5400, C_FLUSH, 1'b1, 1'b0, 2, 0); // 22 LOAD squashed
    addV(1'b0, 1'b0, 16'h0541, C_ADD,   1'b1, 1'b0, 2, 1); // 23 no load record
    addV(1'b0, 1'b0, 16'h8000, C_BR,    1'b1, 1'b0, 2, 1); // 24
    addV(1'b0, 1'b0, 16'hF000, C_FLUSH, 1'b1, 1'b0, 2, 1); // 25 HALT squashed
    addV(1'b0, 1'b0, 16'h9000, C_NOP,   1'b1, 1'b0, 2, 2); // 26 undefined opcode
    addV(1'b0, 1'b0, 16'hF000, C_IDLE,  1'b1, 1'b0, 2, 2); // 27 HALT decoded
    addV(1'b0, 1'b1, 16'h1123, C_IDLE,  1'b0, 1'b1, 2, 2); // 28 start ignored
    addV(1'b0, 1'b0, 16'h1123, C_IDLE,  1'b0, 1'b1, 2, 2); // 29
    addV(1'b0, 1'b1, 16'h1123, C_IDLE,  1'b0, 1'b1, 2, 2); // 30
    addV(1'b0, 1'b1, 16'h8000, C_IDLE,  1'b0, 1'b1, 2, 2); // 31
    addV(1'b1, 1'b1, 16'h0000, C_IDLE,  1'b0, 1'b1, 2, 2); // 32 reset applied
    addV(1'b0, 1'b0, 16'h0000, C_IDLE,  1'b0, 1'b0, 0, 0); // 33 back in IDLE
    addV(1'b0, 1'b1, 16'h5400, C_IDLE,  1'b0, 1'b0, 0, 0); // 34
    addV(1'b0, 1'b0, 16'h5400, C_LOAD,  1'b1, 1'b0, 0, 0); // 35
    addV(1'b0, 1'b0, 16'h0541, C_IDLE,  1'b1, 1'b0, 0, 0); // 36 hazard
    addV(1'b1, 1'b0, 16'h0541, C_ADD,   1'b1, 1'b0, 0, 0); // 37 reset during STALL
    addV(1'b0, 1'b0, 16'h0000, C_IDLE,  1'b0, 1'b0, 0, 0); // 38
    addV(1'b1, 1'b1, 16'h0000, C_IDLE,  1'b0, 1'b0, 0, 0); // 39 reset beats start
    addV(1'b0, 1'b0, 16'h0000, C_IDLE,  1'b0, 1'b0, 0, 0); // 40

    reset  = 1'b1;
    start  = 1'b0;
    inst_d = 16'h0000;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      start  = vecs[i].st;
      inst_d = vecs[i].inst;
      #1;
      checkVal($sformatf("v%0d ctl", i),
               {23'b0, enable, branchC, flushC, RegWriteC, MemWriteC,
                MemToRegC, immediateC, alufuncC}, {23'b0, vecs[i].ctl});
      checkVal($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, vecs[i].bsy});
      checkVal($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].hlt});
      checkVal($sformatf("v%0d stall_cnt", i), {16'b0, stall_cnt}, 32'(vecs[i].s * PERF));
      checkVal($sformatf("v%0d flush_cnt", i), {16'b0, flush_cnt}, 32'(vecs[i].f * PERF));
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
